juego_turnos_fsm: RTL

Parametrised turn-based game controller, successor to the fixed 2-player, 3-bit game FSM of Lab 4. N players take turns submitting move codes. A per-turn timeout counter enforces move deadlines. Each player's score is tracked, and the game stops when one player reaches the win score. It sits between the input debouncers/switch decoders and the display/LED drivers on the board.

---
 rtl/juego_turnos_if.sv | 32 +++
 rtl/juego_turnos_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/juego_turnos_if.sv
// Board-side bus of the turn-based game controller: debounced player inputs in,
// turn/score/status out to the display and LED drivers.
interface juego_turnos_if #(
    parameter int N_PLAYERS = 2,
    parameter int MOVE_W    = 3,
    parameter int WIN_SCORE = 3
);
    localparam int PW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;
    localparam int SW = $clog2(WIN_SCORE + 1);

    logic              start;
    logic              move_valid;
    logic [MOVE_W-1:0] move;
    logic [PW-1:0]     turn;
    logic [MOVE_W-1:0] target;
    logic [SW-1:0]     cur_score;
    logic              move_ok;
    logic              move_hit;
    logic              timeout;
    logic              game_over;
    logic [PW-1:0]     winner;

    modport master (
        output start, move_valid, move,
        input  turn, target, cur_score, move_ok, move_hit, timeout, game_over, winner
    );

    modport slave (
        input  start, move_valid, move,
        output turn, target, cur_score, move_ok, move_hit, timeout, game_over, winner
    );
endinterface

// File: rtl/juego_turnos_fsm.sv
// N-player turn-based game controller with per-turn deadline and win detection.
// Optional build macro JUEGO_PENALTY_EN: an expired turn costs the player one point.

// One player's score register; saturates at WIN_SCORE going up and at 0 going down.
module juego_score_slot #(
    parameter int SW        = 2,
    parameter int WIN_SCORE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [SW-1:0] score_d,
    output logic [SW-1:0] score_q
);
    always_comb begin
        score_d = score_q;
        if (clr)
            score_d = '0;
        else if (inc && score_q != SW'(WIN_SCORE))
            score_d = score_q + SW'(1);
        else if (dec && score_q != '0)
            score_d = score_q - SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) score_q <= '0;
        else      score_q <= score_d;
    end
endmodule

module juego_turnos_fsm #(
    parameter int N_PLAYERS      = 2,
    parameter int MOVE_W         = 3,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int WIN_SCORE      = 3
) (
    input  logic           clk,
    input  logic           rst,
    juego_turnos_if.slave  bus
);
    localparam int PW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] LAST = PW'(N_PLAYERS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MOVE, EVAL, DONE} state_t;

    state_t                         state_q, state_d;
    logic [TW-1:0]                  timer_q, timer_d;
    logic [MOVE_W-1:0]              mv_q, mv_d;
    logic [MOVE_W-1:0]              target_q, target_d;
    logic [PW-1:0]                  turn_q, turn_d;
    logic [PW-1:0]                  winner_q, winner_d;
    logic [SW-1:0]                  cur_q, cur_d;
    logic                           ok_q, ok_d, hit_q, hit_d, to_q, to_d, over_q, over_d;
    logic                           clr;
    logic [N_PLAYERS-1:0]           inc, dec;
    logic [N_PLAYERS-1:0][SW-1:0]   score_q, score_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] t);
        return (t == LAST) ? '0 : t + PW'(1);
    endfunction

    genvar p;
    generate
        for (p = 0; p < N_PLAYERS; p++) begin : g_slot
            juego_score_slot #(.SW(SW), .WIN_SCORE(WIN_SCORE)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr),
                .inc     (inc[p]),
                .dec     (dec[p]),
                .score_d (score_d[p]),
                .score_q (score_q[p])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        mv_d     = mv_q;
        target_d = target_q;
        turn_d   = turn_q;
        winner_d = winner_q;
        over_d   = over_q;
        ok_d     = 1'b0;
        hit_d    = 1'b0;
        to_d     = 1'b0;
        clr      = 1'b0;
        inc      = '0;
        dec      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = WAIT_MOVE;
                    turn_d   = '0;
                    target_d = MOVE_W'(1);
                    timer_d  = '0;
                    winner_d = '0;
                    over_d   = 1'b0;
                    clr      = 1'b1;
                end
            end
            WAIT_MOVE: begin
                // A move arriving in the expiring cycle takes priority over the pass.
                if (bus.move_valid) begin
                    mv_d    = bus.move;
                    state_d = EVAL;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    turn_d  = nxt(turn_q);
                    timer_d = '0;
`ifdef JUEGO_PENALTY_EN
                    dec[turn_q] = 1'b1;
`else
                    dec = '0;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            EVAL: begin
                ok_d    = 1'b1;
                timer_d = '0;
                if (mv_q == target_q) begin
                    hit_d       = 1'b1;
                    inc[turn_q] = 1'b1;
                    target_d    = target_q + MOVE_W'(1);
                end
                // Only a hit can reach the win score; the winner keeps the turn.
                if (mv_q == target_q && score_q[turn_q] == SW'(WIN_SCORE - 1)) begin
                    state_d  = DONE;
                    over_d   = 1'b1;
                    winner_d = turn_q;
                end else begin
                    state_d = WAIT_MOVE;
                    turn_d  = nxt(turn_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cur_d = score_d[turn_d];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            mv_q     <= '0;
            target_q <= MOVE_W'(1);
            turn_q   <= '0;
            winner_q <= '0;
            cur_q    <= '0;
            ok_q     <= 1'b0;
            hit_q    <= 1'b0;
            to_q     <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            mv_q     <= mv_d;
            target_q <= target_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            cur_q    <= cur_d;
            ok_q     <= ok_d;
            hit_q    <= hit_d;
            to_q     <= to_d;
            over_q   <= over_d;
        end
    end

    assign bus.turn      = turn_q;
    assign bus.target    = target_q;
    assign bus.cur_score = cur_q;
    assign bus.move_ok   = ok_q;
    assign bus.move_hit  = hit_q;
    assign bus.timeout   = to_q;
    assign bus.game_over = over_q;
    assign bus.winner    = winner_q;
endmodule
